free_list: RTL and testbench
============================

# free_list

Physical-register free list for the N-way rename stage. It hands unused physical register tags to dispatch through `pr_freelist`, which the rename map table consumes. It takes back the old tags (`pr_old`) of retiring instructions from the ROB. On a branch hazard it restores itself to the architectural (retired) state in one cycle.

## Interface
Parameters:
- `N_WAY`, 2: dispatch/retire width.
- `XLEN`, 32: architectural register count. Physical tags 1..XLEN are mapped at reset.
- `PRF_SIZE`, 64: physical registers. Tag 0 is reserved and means "no register".
- `CDB_BITS`, 6: tag width, equal to log2(PRF_SIZE).
- `FL_DEPTH`, `PRF_SIZE-1-XLEN` (31): maximum free entries.

Ports:
- `clock` in 1: single clock. All state updates on posedge.
- `reset` in 1: asynchronous, active-high. Takes effect immediately; release is synchronous to `clock`.
- `dis_req` in N_WAY: lane k of dispatch needs a destination tag.
- `branch_haz` in 1: flush. Restore the free list to the retired state.
- `ret_valid` in N_WAY: lane k retires an instruction that allocated a tag.
- `ret_pr_old` in N_WAY×CDB_BITS: old tag freed by retire lane k. Never 0 when valid.
- `pr_freelist` out N_WAY×CDB_BITS: tag granted to dispatch lane k, or 0.
- `fl_stall` out 1: the request cannot be granted this cycle.
- `free_count` out CDB_BITS+1: current number of free entries.

## Operation
- Storage is a circular buffer of PRF_SIZE entries × CDB_BITS.
- Pointers `head`, `tail` and `arch_head` are each CDB_BITS+1 bits wide, with a wrap bit. Index = ptr[CDB_BITS-1:0].
- `free_count` = tail − head (modulo 2^(CDB_BITS+1)), held as a register.
- Reset values:
  - entry[i] = XLEN+1+i for i < FL_DEPTH. Other entries are don't-care.
  - head = arch_head = 0, tail = FL_DEPTH, free_count = FL_DEPTH.
- Allocation is combinational:
  - r = popcount(dis_req).
  - If branch_haz = 1 or r > free_count: `fl_stall` = 1, all `pr_freelist` = 0, no pop.
  - Otherwise `fl_stall` = 0. The i-th requesting lane (lane order, lowest first) gets entry[head+i]; non-requesting lanes get 0. On posedge, head += r.
- All-or-nothing: a partial grant is never made.
- Free (retire): the i-th valid retire lane writes ret_pr_old to entry[tail+i]. On posedge, tail += popcount(ret_valid) and arch_head += popcount(ret_valid).
  - Rationale: allocation and retirement are both in program order, so arch_head tracks the oldest tag still owned by an in-flight instruction.
- Recovery: when branch_haz = 1, on posedge head <= arch_head + popcount(ret_valid). This returns every speculatively allocated tag. Same-cycle retirement is applied normally.
- free_count is recomputed from the next-state head/tail every cycle.
- Invariant: free_count ≤ FL_DEPTH at all times, so the buffer never overflows. Overflow or a ret_pr_old = 0 with ret_valid set is a protocol error and is covered by assertions only.
- Pushed tags are visible to allocation the cycle after the push. There is no same-cycle bypass from retire to dispatch.

## Timing
- `pr_freelist` and `fl_stall` are combinational from head, free_count, dis_req and branch_haz: zero-cycle grant latency.
- free_count, head, tail and arch_head update on posedge. Their effect on the outputs is visible in the next cycle.
- Simultaneous allocate and free in one cycle: the grant uses the old free_count. The net change is −r + popcount(ret_valid).
- Empty (free_count = 0): any request stalls. With free_count = 1 and r = 2, both lanes stall and no tag is consumed.
- Wrap-around: pointer indices wrap modulo PRF_SIZE. The wrap bit distinguishes the empty case from a full buffer.
- Reset asserted mid-operation: all pointers and entries return to their reset values immediately. Outputs read as the reset state: grants come from tags 33, 34, ….

## Test plan
- Reset, then dis_req = 2'b11 -> pr_freelist = {34, 33} (lane0 = 33), fl_stall = 0. Next cycle free_count = 29.
- Reset, then dis_req = 2'b10 -> lane1 = 33, lane0 = 0. free_count becomes 30.
- Allocate 2 per cycle for 15 cycles -> free_count = 1. Then dis_req = 2'b11 -> fl_stall = 1, both outputs 0, free_count stays 1.
- Allocate 33, 34. Then retire ret_valid = 2'b11, ret_pr_old = {5, 7}. After more allocations wrap the pointers, the grants eventually return 7, then 5, in order.
- Allocate 6 tags and retire 2 (pr_old 1, 2). Then assert branch_haz -> next cycle free_count = 31 − 6 + 2 + 4 = 31. The next grant is the oldest un-retired speculative tag (35).
- branch_haz with ret_valid = 2'b01 in the same cycle, and dis_req = 2'b11 -> fl_stall = 1. Head restored to arch_head + 1; the retired tag is appended at tail.

Source files
------------

// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: dispatch requests, retire frees, flush and grants.
interface free_list_if #(
    parameter int unsigned N_WAY    = 2,
    parameter int unsigned CDB_BITS = 6
);
    logic [N_WAY-1:0]                dis_req;
    logic                            branch_haz;
    logic [N_WAY-1:0]                ret_valid;
    logic [N_WAY-1:0][CDB_BITS-1:0]  ret_pr_old;
    logic [N_WAY-1:0][CDB_BITS-1:0]  pr_freelist;
    logic                            fl_stall;
    logic [CDB_BITS:0]               free_count;

    // Rename/ROB side drives requests and frees, observes grants.
    modport master (
        output dis_req, branch_haz, ret_valid, ret_pr_old,
        input  pr_freelist, fl_stall, free_count
    );

    // Free list side consumes requests and frees, produces grants.
    modport slave (
        input  dis_req, branch_haz, ret_valid, ret_pr_old,
        output pr_freelist, fl_stall, free_count
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of tags with speculative head,
// retire tail and architectural head used for single-cycle flush recovery.
module free_list #(
    parameter int unsigned N_WAY    = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PRF_SIZE = 64,
    parameter int unsigned CDB_BITS = 6,
    parameter int unsigned FL_DEPTH = PRF_SIZE - 1 - XLEN
) (
    input  logic       clock,
    input  logic       reset,
    free_list_if.slave fl
);

    localparam int unsigned PTR_W = CDB_BITS + 1;

    typedef logic [PTR_W-1:0]    ptr_t;
    typedef logic [CDB_BITS-1:0] tag_t;

    tag_t entries_q [PRF_SIZE];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t arch_head_q, arch_head_d;
    ptr_t free_count_q, free_count_d;
    ptr_t req_cnt;
    ptr_t ret_cnt;
    ptr_t alloc_cnt;
    logic grant;
    tag_t wr_idx [N_WAY];

    // Count requests and retirements; give each valid retire lane its slot after tail.
    always_comb begin
        req_cnt = '0;
        ret_cnt = '0;
        for (int unsigned k = 0; k < N_WAY; k++) begin
            wr_idx[k] = CDB_BITS'(tail_q + ret_cnt);
            req_cnt   = req_cnt + PTR_W'(fl.dis_req[k]);
            ret_cnt   = ret_cnt + PTR_W'(fl.ret_valid[k]);
        end
    end

    // All-or-nothing grant: requesting lanes take consecutive entries from head.
    always_comb begin
        grant          = !fl.branch_haz && (req_cnt <= free_count_q);
        fl.fl_stall    = !grant;
        fl.pr_freelist = '0;
        alloc_cnt      = '0;
        for (int unsigned k = 0; k < N_WAY; k++) begin
            if (grant && fl.dis_req[k]) begin
                fl.pr_freelist[k] = entries_q[CDB_BITS'(head_q + alloc_cnt)];
                alloc_cnt         = alloc_cnt + PTR_W'(1);
            end
        end
    end

    // Pointer next state; a flush rewinds head to the retired point.
    always_comb begin
        tail_d      = tail_q + ret_cnt;
        arch_head_d = arch_head_q + ret_cnt;
        head_d      = head_q;
        if (fl.branch_haz) begin
            head_d = arch_head_q + ret_cnt;
        end else if (grant) begin
            head_d = head_q + req_cnt;
        end
        free_count_d = tail_d - head_d;
    end

    assign fl.free_count = free_count_q;

    // State registers and retire writes into the tag buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q       <= '0;
            arch_head_q  <= '0;
            tail_q       <= PTR_W'(FL_DEPTH);
            free_count_q <= PTR_W'(FL_DEPTH);
            for (int unsigned i = 0; i < PRF_SIZE; i++) begin
                entries_q[i] <= (i < FL_DEPTH) ? CDB_BITS'(XLEN + 1 + i) : '0;
            end
        end else begin
            head_q       <= head_d;
            arch_head_q  <= arch_head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            for (int unsigned k = 0; k < N_WAY; k++) begin
                if (fl.ret_valid[k]) begin
                    entries_q[wr_idx[k]] <= fl.ret_pr_old[k];
                end
            end
        end
    end

    // The buffer can never hold more than the free-able tag population.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        free_count_q <= PTR_W'(FL_DEPTH));

    // Tag 0 means "no register" and must never be returned.
    for (genvar k = 0; k < int'(N_WAY); k++) begin : g_ret_chk
        a_ret_nonzero: assert property (@(posedge clock) disable iff (reset)
            fl.ret_valid[k] |-> (fl.ret_pr_old[k] != '0));
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus random traffic against a tag-queue model.
module tb_free_list;

    logic clock;
    logic reset;

    free_list_if #(.N_WAY(2), .CDB_BITS(6)) fl ();

    free_list #(
        .N_WAY(2), .XLEN(32), .PRF_SIZE(64), .CDB_BITS(6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl.slave)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model: free tags in grant order, allocated-but-unretired tags, and tags owned by retired state.
    int free_q[$];
    int inflight[$];
    int owned[$];

    int pend_alloc;
    int pend_nret;
    bit pend_haz;
    int pend_tags[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        inflight.delete();
        owned.delete();
        for (int i = 0; i < 31; i++) free_q.push_back(33 + i);
        for (int i = 1; i <= 32; i++) owned.push_back(i);
    endtask

    // Assert reset between edges and confirm the outputs snap back immediately.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        fl.dis_req    = 2'b11;
        fl.branch_haz = 1'b0;
        fl.ret_valid  = 2'b00;
        fl.ret_pr_old = '0;
        reset = 1'b1;
        #1;
        check("rst_free_count", int'(fl.free_count), 31);
        check("rst_stall", int'(fl.fl_stall), 0);
        check("rst_lane0", int'(fl.pr_freelist[0]), 33);
        check("rst_lane1", int'(fl.pr_freelist[1]), 34);
        model_reset();
        @(posedge clock);
        #1;
        fl.dis_req = 2'b00;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one cycle's inputs and compare the combinational outputs with the model.
    task automatic drive(input logic [1:0] dreq, input logic haz, input logic [1:0] rv,
                         input bit force_tags, input int t0, input int t1);
        int r;
        int n;
        int tag;
        int idx;
        bit exp_stall;
        int exp_tag;
        @(negedge clock);
        fl.dis_req    = dreq;
        fl.branch_haz = haz;
        fl.ret_valid  = rv;
        pend_tags.delete();
        for (int k = 0; k < 2; k++) begin
            if (rv[k]) begin
                if (force_tags) begin
                    tag = (k == 0) ? t0 : t1;
                    for (int j = 0; j < owned.size(); j++) begin
                        if (owned[j] == tag) begin
                            owned.delete(j);
                            break;
                        end
                    end
                end else begin
                    idx = $urandom_range(owned.size() - 1);
                    tag = owned[idx];
                    owned.delete(idx);
                end
                fl.ret_pr_old[k] = 6'(tag);
                pend_tags.push_back(tag);
            end else begin
                fl.ret_pr_old[k] = '0;
            end
        end
        #1;
        r = int'(dreq[0]) + int'(dreq[1]);
        exp_stall = haz || (r > free_q.size());
        check("stall", int'(fl.fl_stall), int'(exp_stall));
        check("free_count", int'(fl.free_count), free_q.size());
        n = 0;
        for (int k = 0; k < 2; k++) begin
            exp_tag = 0;
            if (!exp_stall && dreq[k]) begin
                exp_tag = free_q[n];
                n++;
            end
            check($sformatf("grant_lane%0d", k), int'(fl.pr_freelist[k]), exp_tag);
        end
        pend_alloc = exp_stall ? 0 : r;
        pend_nret  = int'(rv[0]) + int'(rv[1]);
        pend_haz   = haz;
    endtask

    // Advance the model across the clock edge.
    task automatic commit();
        @(posedge clock);
        repeat (pend_alloc) inflight.push_back(free_q.pop_front());
        repeat (pend_nret) owned.push_back(inflight.pop_front());
        foreach (pend_tags[i]) free_q.push_back(pend_tags[i]);
        if (pend_haz) begin
            for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i]);
            inflight.delete();
        end
    endtask

    task automatic step(input logic [1:0] dreq, input logic haz, input logic [1:0] rv);
        drive(dreq, haz, rv, 1'b0, 0, 0);
        commit();
    endtask

    initial begin
        logic [1:0] dreq;
        logic [1:0] rv;
        logic       haz;
        reset         = 1'b1;
        fl.dis_req    = '0;
        fl.branch_haz = 1'b0;
        fl.ret_valid  = '0;
        fl.ret_pr_old = '0;

        // Dual grant straight out of reset.
        apply_reset();
        drive(2'b11, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp1_lane0", int'(fl.pr_freelist[0]), 33);
        check("tp1_lane1", int'(fl.pr_freelist[1]), 34);
        commit();
        drive(2'b00, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp1_count", int'(fl.free_count), 29);
        commit();

        // Single request on the upper lane takes the first tag.
        apply_reset();
        drive(2'b10, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp2_lane1", int'(fl.pr_freelist[1]), 33);
        check("tp2_lane0", int'(fl.pr_freelist[0]), 0);
        commit();
        drive(2'b00, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp2_count", int'(fl.free_count), 30);
        commit();

        // Drain to one entry; a two-wide request must stall without consuming it.
        apply_reset();
        repeat (15) step(2'b11, 1'b0, 2'b00);
        drive(2'b11, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp3_stall", int'(fl.fl_stall), 1);
        check("tp3_count", int'(fl.free_count), 1);
        commit();
        drive(2'b00, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp3_count_hold", int'(fl.free_count), 1);
        commit();

        // Freed tags come back in retire-lane order after the original pool.
        apply_reset();
        step(2'b11, 1'b0, 2'b00);
        drive(2'b00, 1'b0, 2'b11, 1'b1, 7, 5);
        commit();
        repeat (14) step(2'b11, 1'b0, 2'b00);
        drive(2'b11, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp4_lane0", int'(fl.pr_freelist[0]), 63);
        check("tp4_lane1", int'(fl.pr_freelist[1]), 7);
        commit();
        drive(2'b01, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp4_last", int'(fl.pr_freelist[0]), 5);
        commit();

        // Flush after six allocations and two retirements.
        apply_reset();
        repeat (3) step(2'b11, 1'b0, 2'b00);
        drive(2'b00, 1'b0, 2'b11, 1'b1, 1, 2);
        commit();
        drive(2'b00, 1'b1, 2'b00, 1'b0, 0, 0);
        commit();
        drive(2'b01, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp5_count", int'(fl.free_count), 31);
        check("tp5_grant", int'(fl.pr_freelist[0]), 35);
        commit();

        // Flush with a same-cycle retirement and a blocked request.
        apply_reset();
        step(2'b11, 1'b0, 2'b00);
        step(2'b11, 1'b0, 2'b00);
        drive(2'b11, 1'b1, 2'b01, 1'b0, 0, 0);
        check("tp6_stall", int'(fl.fl_stall), 1);
        commit();
        drive(2'b01, 1'b0, 2'b00, 1'b0, 0, 0);
        check("tp6_count", int'(fl.free_count), 31);
        check("tp6_grant", int'(fl.pr_freelist[0]), 34);
        commit();

        // Random traffic with occasional flushes and mid-run resets; pointers wrap many times.
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 700 == 699) apply_reset();
            dreq = 2'($urandom);
            haz  = ($urandom_range(15) == 0);
            rv   = 2'($urandom);
            if (inflight.size() == 0) begin
                rv = 2'b00;
            end else if (inflight.size() == 1 && rv == 2'b11) begin
                rv = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
            end
            step(dreq, haz, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
